// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops bytes from the TX FIFO head and shifts them out
// as start / 5-8 data / optional parity / 1, 1.5 or 2 stop bit frames.
module uart_tx_engine #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_pop,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    input  logic       bc,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned TICK_W = $clog2(2 * OVERSAMPLE);
    localparam logic [TICK_W-1:0] BIT_LAST    = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP15_LAST = TICK_W'((3 * OVERSAMPLE) / 2 - 1);
    localparam logic [TICK_W-1:0] STOP2_LAST  = TICK_W'(2 * OVERSAMPLE - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [1:0]        wls_q, wls_d;
    logic              stb_q, stb_d;
    logic              pen_q, pen_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [TICK_W-1:0] tick_last;
    logic              bit_end;

    // Parity over the active data bits only; stick parity overrides the computed value.
    function automatic logic frame_parity(input logic [7:0] d, input logic [1:0] w,
                                          input logic e, input logic s);
        logic [7:0] mask;
        logic       odd_ones;
        case (w)
            2'b00:   mask = 8'h1F;
            2'b01:   mask = 8'h3F;
            2'b10:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        odd_ones = ^(d & mask);
        if (s) begin
            return ~e;
        end
        return e ? odd_ones : ~odd_ones;
    endfunction

    // Stop period is longer than a data bit when two (or one and a half) stop bits are selected.
    always_comb begin
        tick_last = BIT_LAST;
        if (state_q == STOP && stb_q) begin
            tick_last = (wls_q == 2'b00) ? STOP15_LAST : STOP2_LAST;
        end
    end

    assign bit_end = baud_tick && (tick_q == tick_last);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        wls_d    = wls_q;
        stb_d    = stb_q;
        pen_d    = pen_q;
        par_d    = par_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;

        if (state_q != IDLE && baud_tick) begin
            tick_d = bit_end ? '0 : tick_q + TICK_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (rst && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    wls_d    = wls;
                    stb_d    = stb;
                    pen_d    = pen;
                    par_d    = frame_parity(fifo_dout, wls, eps, sp);
                    bit_d    = '0;
                    tick_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd4 + 3'(wls_q)) begin
                        bit_d   = '0;
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        if (bc) begin
            tx_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wls_q   <= '0;
            stb_q   <= 1'b0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wls_q   <= wls_d;
            stb_q   <= stb_d;
            pen_q   <= pen_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: FIFO model, tick-indexed line checks, pop accounting.
module tb_uart_tx_engine;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_pop;
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sp;
    logic       bc;
    logic       tx;
    logic       busy;
    logic       tx_done;

    logic [7:0] q[$];
    int         pop_cnt  = 0;
    int         bad_pop  = 0;
    int         cyc      = 0;
    int         tick_div = 1;
    int         n_vec    = 0;
    int         n_err    = 0;

    uart_tx_engine #(.OVERSAMPLE(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_pop   (fifo_pop),
        .wls        (wls),
        .stb        (stb),
        .pen        (pen),
        .eps        (eps),
        .sp         (sp),
        .bc         (bc),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO read side: the head leaves the queue on every accepted pop.
    always @(posedge clk) begin
        if (fifo_pop) begin
            pop_cnt <= pop_cnt + 1;
            if (q.size() == 0) begin
                bad_pop <= bad_pop + 1;
            end else begin
                void'(q.pop_front());
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        baud_tick  = (tick_div <= 1) ? 1'b1 : ((cyc % tick_div) == 0);
        fifo_empty = (q.size() == 0);
        fifo_dout  = fifo_empty ? 8'h00 : q[0];
    endtask

    task automatic push(input logic [7:0] d);
        q.push_back(d);
        fifo_empty = 1'b0;
        fifo_dout  = q[0];
    endtask

    task automatic wait_pop(output int w);
        int base;
        base = pop_cnt;
        w = 0;
        while (pop_cnt == base && w < 64) begin
            step();
            w++;
        end
    endtask

    // Walks one frame by counting baud ticks since the pop; samples at quarter-bit points.
    task automatic watch_frame(input string tag, input logic [7:0] d, input int nbits,
                               input logic has_par, input logic par, input int stop_ticks,
                               input int bcf, input int bct);
        int   n, last, total, guard, idx;
        logic e;
        total = (1 + nbits + int'(has_par)) * 16 + stop_ticks;
        n = 0;
        last = -1;
        guard = 0;
        while (n < total && guard < 4000) begin
            if (n != last) begin
                last = n;
                if (n == bcf) bc = 1'b1;
                if (n == bct) bc = 1'b0;
                if (n == 0) check({tag, "_busy"}, int'(busy), 1);
                if (n % 8 == 4) begin
                    idx = n / 16;
                    if (idx == 0)                            e = 1'b0;
                    else if (idx <= nbits)                   e = d[idx-1];
                    else if (has_par && idx == nbits + 1)    e = par;
                    else                                     e = 1'b1;
                    if (n >= bcf && n < bct) e = 1'b0;
                    check($sformatf("%s_tx%0d", tag, n), int'(tx), int'(e));
                end
                if (n == total - 1) check({tag, "_done_early"}, int'(tx_done), 0);
            end
            n += int'(baud_tick);
            step();
            guard++;
        end
        check({tag, "_len"}, n, total);
        check({tag, "_done"}, int'(tx_done), 1);
        check({tag, "_idle_busy"}, int'(busy), 0);
        check({tag, "_idle_tx"}, int'(tx), 1);
    endtask

    // One isolated frame; config is scrambled after the pop to prove it was latched.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] w,
                             input logic p, input logic e, input logic s, input logic st,
                             input logic exp_par, input int exp_stop, input int bcf,
                             input int bct);
        int wc;
        wls = w; pen = p; eps = e; sp = s; stb = st;
        push(d);
        wait_pop(wc);
        check({tag, "_pop_wait"}, wc, 1);
        wls = ~w; pen = ~p; eps = ~e; sp = ~s; stb = ~st;
        watch_frame(tag, d, int'(w) + 5, p, exp_par, exp_stop, bcf, bct);
        step();
        check({tag, "_done_pulse"}, int'(tx_done), 0);
    endtask

    initial begin
        int w;
        rst = 1'b0; baud_tick = 1'b1; fifo_empty = 1'b1; fifo_dout = 8'h00;
        wls = 2'b11; stb = 1'b0; pen = 1'b0; eps = 1'b0; sp = 1'b0; bc = 1'b0;

        // Reset held with data waiting: nothing moves.
        push(8'h55);
        repeat (3) step();
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(tx_done), 0);
        check("rst_pops", pop_cnt, 0);
        rst = 1'b1;
        wait_pop(w);
        check("rel_pop_wait", w, 1);
        wls = 2'b00; pen = 1'b1; stb = 1'b1; eps = 1'b1; sp = 1'b1;
        watch_frame("b55", 8'h55, 8, 1'b0, 1'b0, 16, -1, -1);
        step();
        check("b55_done_pulse", int'(tx_done), 0);

        // Parity variants on 0x07 (three ones).
        run_frame("par_even", 8'h07, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16, -1, -1);
        run_frame("par_odd",  8'h07, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16, -1, -1);
        run_frame("par_stk",  8'h07, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16, -1, -1);

        // Five data bits with 1.5 stop bits; bits 7:5 never appear.
        run_frame("w5_s15", 8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24, -1, -1);

        // Back-to-back frames with a single idle cycle between them.
        wls = 2'b11; pen = 1'b0; stb = 1'b0; eps = 1'b0; sp = 1'b0;
        push(8'hA5);
        push(8'h3C);
        wait_pop(w);
        check("b2b_a_wait", w, 1);
        watch_frame("b2b_a", 8'hA5, 8, 1'b0, 1'b0, 16, -1, -1);
        wait_pop(w);
        check("b2b_b_wait", w, 1);
        watch_frame("b2b_b", 8'h3C, 8, 1'b0, 1'b0, 16, -1, -1);
        repeat (10) step();
        check("b2b_pops", pop_cnt, 7);
        check("b2b_tx_idle", int'(tx), 1);

        // Break mid-frame: line held low, frame timing unchanged.
        run_frame("brk", 8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16, 32, 72);

        // Seven bits, even parity excluding bit 7, two stop bits, slow ticks.
        tick_div = 2;
        run_frame("w7_even", 8'hB1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32, -1, -1);
        tick_div = 1;

        // Six bits, odd parity, two stop bits.
        run_frame("w6_odd", 8'h2C, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32, -1, -1);

        // Reset in the middle of DATA while bit 2 (a zero) is on the line.
        wls = 2'b11; pen = 1'b0; stb = 1'b0;
        push(8'hC3);
        wait_pop(w);
        check("mrst_pop_wait", w, 1);
        repeat (56) step();
        check("mrst_pre_tx", int'(tx), 0);
        rst = 1'b0;
        step();
        check("mrst_tx", int'(tx), 1);
        check("mrst_busy", int'(busy), 0);
        rst = 1'b1;
        repeat (20) step();
        check("mrst_after_tx", int'(tx), 1);
        check("mrst_after_busy", int'(busy), 0);

        // Break while idle.
        bc = 1'b1;
        step();
        check("brk_idle_tx", int'(tx), 0);
        check("brk_idle_busy", int'(busy), 0);
        bc = 1'b0;
        step();
        check("brk_rel_tx", int'(tx), 1);

        check("total_pops", pop_cnt, 11);
        check("pop_when_empty", bad_pop, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
